// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared types and constants for the 6502 control unit slice:
//               FSM states, ALU opcodes, operand selects, opcode bytes and
//               instruction classes.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_RESET   = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_ZP_READ = 3'd3,
    ST_HALT    = 3'd4
  } state_t;

  // ALU opcodes
  localparam logic [1:0] ALU_PASS_B = 2'b00;
  localparam logic [1:0] ALU_ADC    = 2'b01;
  localparam logic [1:0] ALU_AND    = 2'b10;
  localparam logic [1:0] ALU_ORA    = 2'b11;

  // ALU A-operand selects (2'b11 reserved)
  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_X = 2'b01;
  localparam logic [1:0] SEL_Y = 2'b10;

  // Supported opcode bytes
  localparam logic [7:0] OP_LDA_IMM = 8'hA9;
  localparam logic [7:0] OP_LDX_IMM = 8'hA2;
  localparam logic [7:0] OP_LDY_IMM = 8'hA0;
  localparam logic [7:0] OP_ADC_IMM = 8'h69;
  localparam logic [7:0] OP_AND_IMM = 8'h29;
  localparam logic [7:0] OP_ORA_IMM = 8'h09;
  localparam logic [7:0] OP_LDA_ZP  = 8'hA5;
  localparam logic [7:0] OP_LDX_ZP  = 8'hA6;
  localparam logic [7:0] OP_LDY_ZP  = 8'hA4;
  localparam logic [7:0] OP_NOP     = 8'hEA;
  localparam logic [7:0] OP_JAM     = 8'h02;

  // Instruction classes
  typedef enum logic [2:0] {
    CLS_IMM     = 3'd0,
    CLS_ZP      = 3'd1,
    CLS_NOP     = 3'd2,
    CLS_JAM     = 3'd3,
    CLS_ILLEGAL = 3'd4
  } inst_class_t;

  // Destination register of a load/logic instruction
  typedef enum logic [1:0] {
    TGT_NONE = 2'd0,
    TGT_A    = 2'd1,
    TGT_X    = 2'd2,
    TGT_Y    = 2'd3
  } target_t;

endpackage
`default_nettype wire

// File: rtl/opcode_decoder.sv
`default_nettype none
// ============================================================================
// Module      : opcode_decoder
// Description : Purely combinational classification of the instruction byte
//               into class, destination register and ALU operation.
// Revision    : 1.0 - initial release
// ============================================================================
module opcode_decoder
  import cpu_pkg::*;
(
  input  logic [7:0]  opcode,
  output inst_class_t inst_class,
  output target_t     target,
  output logic [1:0]  alu_op
);

  // Table lookup; anything not listed is reported as illegal
  always_comb begin
    inst_class = CLS_ILLEGAL;
    target     = TGT_NONE;
    alu_op     = ALU_PASS_B;
    case (opcode)
      OP_LDA_IMM: begin inst_class = CLS_IMM; target = TGT_A; end
      OP_LDX_IMM: begin inst_class = CLS_IMM; target = TGT_X; end
      OP_LDY_IMM: begin inst_class = CLS_IMM; target = TGT_Y; end
      OP_ADC_IMM: begin inst_class = CLS_IMM; target = TGT_A; alu_op = ALU_ADC; end
      OP_AND_IMM: begin inst_class = CLS_IMM; target = TGT_A; alu_op = ALU_AND; end
      OP_ORA_IMM: begin inst_class = CLS_IMM; target = TGT_A; alu_op = ALU_ORA; end
      OP_LDA_ZP:  begin inst_class = CLS_ZP;  target = TGT_A; end
      OP_LDX_ZP:  begin inst_class = CLS_ZP;  target = TGT_X; end
      OP_LDY_ZP:  begin inst_class = CLS_ZP;  target = TGT_Y; end
      OP_NOP:     inst_class = CLS_NOP;
      OP_JAM:     inst_class = CLS_JAM;
      default:    inst_class = CLS_ILLEGAL;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module      : control_unit
// Description : Sequencing FSM for the 6502 datapath subset (immediate and
//               zero-page loads/logic, NOP, JAM). Outputs are decoded from
//               the registered state and the current opcode; only the
//               zero-page operand address is held in a register.
// Revision    : 1.0 - initial release
// ============================================================================
module control_unit
  import cpu_pkg::*;
#(
  parameter int RESET_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] opcode,
  input  logic [7:0] data_read,
  output logic       increment_pc,
  output logic       instruction_load,
  output logic       a_load,
  output logic       x_load,
  output logic       y_load,
  output logic       address_select,
  output logic [7:0] zp_address,
  output logic [1:0] arithmetic_select,
  output logic [1:0] alu_opcode,
  output logic       read_write,
  output logic       halted,
  output logic       illegal_op
);

  localparam int CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESET_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] reset_count;
  inst_class_t      dec_class;
  target_t          dec_target;
  logic [1:0]       dec_alu_op;
  logic             load_en;

  opcode_decoder u_decoder (
    .opcode     (opcode),
    .inst_class (dec_class),
    .target     (dec_target),
    .alu_op     (dec_alu_op)
  );

  // State register, reset-hold counter and zero-page address latch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_RESET;
      reset_count <= '0;
      zp_address  <= 8'h00;
    end else begin
      case (state)
        ST_RESET: begin
          if (reset_count == CNT_LAST) begin
            state       <= ST_FETCH;
            reset_count <= '0;
          end else begin
            reset_count <= reset_count + 1'b1;
          end
        end
        ST_FETCH: state <= ST_DECODE;
        ST_DECODE: begin
          case (dec_class)
            CLS_ZP: begin
              zp_address <= data_read;
              state      <= ST_ZP_READ;
            end
            CLS_JAM: state <= ST_HALT;
            default: state <= ST_FETCH;
          endcase
        end
        ST_ZP_READ: state <= ST_FETCH;
        ST_HALT:    state <= ST_HALT;
        default:    state <= ST_RESET;
      endcase
    end
  end

  // Control-wire decode from state and current opcode
  always_comb begin
    increment_pc      = 1'b0;
    instruction_load  = 1'b0;
    load_en           = 1'b0;
    address_select    = 1'b0;
    arithmetic_select = SEL_A;
    alu_opcode        = ALU_PASS_B;
    halted            = 1'b0;
    illegal_op        = 1'b0;
    case (state)
      ST_FETCH: begin
        instruction_load = 1'b1;
        increment_pc     = 1'b1;
      end
      ST_DECODE: begin
        case (dec_class)
          CLS_IMM: begin
            increment_pc = 1'b1;
            load_en      = 1'b1;
            alu_opcode   = dec_alu_op;
          end
          CLS_ZP:      increment_pc = 1'b1;
          CLS_ILLEGAL: illegal_op   = 1'b1;
          default:     ;
        endcase
      end
      ST_ZP_READ: begin
        address_select = 1'b1;
        load_en        = 1'b1;
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  // One-hot register load steering; no stores exist so the bus always reads
  assign a_load     = load_en && (dec_target == TGT_A);
  assign x_load     = load_en && (dec_target == TGT_X);
  assign y_load     = load_en && (dec_target == TGT_Y);
  assign read_write = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_unit
// Description : Directed-vector bench for control_unit with hand-computed
//               expected control words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] opcode;
  logic [7:0] data_read;
  logic       increment_pc, instruction_load, a_load, x_load, y_load;
  logic       address_select, read_write, halted, illegal_op;
  logic [7:0] zp_address;
  logic [1:0] arithmetic_select, alu_opcode;

  int n_vec = 0;
  int n_err = 0;

  control_unit #(.RESET_CYCLES(2)) dut (
    .clk               (clk),
    .reset             (reset),
    .opcode            (opcode),
    .data_read         (data_read),
    .increment_pc      (increment_pc),
    .instruction_load  (instruction_load),
    .a_load            (a_load),
    .x_load            (x_load),
    .y_load            (y_load),
    .address_select    (address_select),
    .zp_address        (zp_address),
    .arithmetic_select (arithmetic_select),
    .alu_opcode        (alu_opcode),
    .read_write        (read_write),
    .halted            (halted),
    .illegal_op        (illegal_op)
  );

  always #5 clk = ~clk;

  // Packed observation: {inc, il, a, x, y, asel, arith[1:0], alu[1:0], rw, halted, illegal}
  logic [12:0] ctl;
  assign ctl = {increment_pc, instruction_load, a_load, x_load, y_load,
                address_select, arithmetic_select, alu_opcode, read_write,
                halted, illegal_op};

  // Expected control word; arithmetic_select is always A and read_write 1 here
  function automatic logic [12:0] ec(input logic inc, input logic il,
                                     input logic a, input logic x, input logic y,
                                     input logic asel, input logic [1:0] alu,
                                     input logic h, input logic ill);
    return {inc, il, a, x, y, asel, 2'b00, alu, 1'b1, h, ill};
  endfunction

  localparam logic [12:0] IDLE  = 13'b0_0_000_0_00_00_1_0_0;
  localparam logic [12:0] FETCH = 13'b1_1_000_0_00_00_1_0_0;

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply opcode/operand for the current cycle, then sample
  task automatic vec(input string tag, input logic [7:0] op, input logic [7:0] d,
                     input logic [12:0] exp);
    opcode    = op;
    data_read = d;
    #1;
    check(tag, {3'b000, ctl}, {3'b000, exp});
  endtask

  initial begin
    reset     = 1'b1;
    opcode    = 8'hEA;
    data_read = 8'h00;
    #12;
    check("reset_ctl", {3'b000, ctl}, {3'b000, IDLE});
    check("reset_zp", {8'h00, zp_address}, 16'h0000);

    // Release just after an edge: two RESET cycles, then FETCH
    tick();
    reset = 1'b0;
    vec("rst_cyc1", 8'hEA, 8'h00, IDLE);
    tick(); vec("rst_cyc2", 8'hEA, 8'h00, IDLE);
    tick(); vec("fetch_first", 8'hEA, 8'h00, FETCH);

    // LDA #42
    tick(); vec("lda_imm_dec", 8'hA9, 8'h42, ec(1,0,1,0,0,0,2'b00,0,0));
    tick(); vec("lda_imm_fetch", 8'hA9, 8'h42, FETCH);

    // LDX $10 : DECODE, ZP_READ, FETCH
    tick(); vec("ldx_zp_dec", 8'hA6, 8'h10, ec(1,0,0,0,0,0,2'b00,0,0));
    tick(); vec("ldx_zp_read", 8'hA6, 8'hEE, ec(0,0,0,1,0,1,2'b00,0,0));
    check("ldx_zp_addr", {8'h00, zp_address}, 16'h0010);
    tick(); vec("ldx_zp_fetch", 8'hA6, 8'hEE, FETCH);

    // ADC #05, AND #0F
    tick(); vec("adc_imm_dec", 8'h69, 8'h05, ec(1,0,1,0,0,0,2'b01,0,0));
    tick(); vec("adc_fetch", 8'h69, 8'h05, FETCH);
    tick(); vec("and_imm_dec", 8'h29, 8'h0F, ec(1,0,1,0,0,0,2'b10,0,0));
    tick(); vec("and_fetch", 8'h29, 8'h0F, FETCH);

    // ORA #, LDX #, LDY #
    tick(); vec("ora_imm_dec", 8'h09, 8'h33, ec(1,0,1,0,0,0,2'b11,0,0));
    tick(); vec("ora_fetch", 8'h09, 8'h33, FETCH);
    tick(); vec("ldx_imm_dec", 8'hA2, 8'h01, ec(1,0,0,1,0,0,2'b00,0,0));
    tick(); vec("ldx_fetch", 8'hA2, 8'h01, FETCH);
    tick(); vec("ldy_imm_dec", 8'hA0, 8'h02, ec(1,0,0,0,1,0,2'b00,0,0));
    tick(); vec("ldy_fetch", 8'hA0, 8'h02, FETCH);

    // LDY $80 and LDA $FF
    tick(); vec("ldy_zp_dec", 8'hA4, 8'h80, ec(1,0,0,0,0,0,2'b00,0,0));
    tick(); vec("ldy_zp_read", 8'hA4, 8'h00, ec(0,0,0,0,1,1,2'b00,0,0));
    check("ldy_zp_addr", {8'h00, zp_address}, 16'h0080);
    tick(); vec("ldy_zp_fetch", 8'hA4, 8'h00, FETCH);
    tick(); vec("lda_zp_dec", 8'hA5, 8'hFF, ec(1,0,0,0,0,0,2'b00,0,0));
    tick(); vec("lda_zp_read", 8'hA5, 8'h00, ec(0,0,1,0,0,1,2'b00,0,0));
    check("lda_zp_addr", {8'h00, zp_address}, 16'h00FF);
    tick(); vec("lda_zp_fetch", 8'hA5, 8'h00, FETCH);

    // Illegal FF pulses once, NOP does nothing
    tick(); vec("illegal_dec", 8'hFF, 8'h00, ec(0,0,0,0,0,0,2'b00,0,1));
    tick(); vec("illegal_fetch", 8'hFF, 8'h00, FETCH);
    tick(); vec("nop_dec", 8'hEA, 8'h00, IDLE);
    tick(); vec("nop_fetch", 8'hEA, 8'h00, FETCH);

    // Reset asserted mid ZP_READ drops everything asynchronously
    tick(); vec("ldx_zp2_dec", 8'hA6, 8'h77, ec(1,0,0,0,0,0,2'b00,0,0));
    tick(); vec("ldx_zp2_read", 8'hA6, 8'h00, ec(0,0,0,1,0,1,2'b00,0,0));
    check("ldx_zp2_addr", {8'h00, zp_address}, 16'h0077);
    #1 reset = 1'b1;
    #1;
    check("async_rst_ctl", {3'b000, ctl}, {3'b000, IDLE});
    check("async_rst_zp", {8'h00, zp_address}, 16'h0000);
    tick();
    reset = 1'b0;
    vec("rst2_cyc1", 8'hEA, 8'h00, IDLE);
    tick(); vec("rst2_cyc2", 8'hEA, 8'h00, IDLE);
    tick(); vec("rst2_fetch", 8'hEA, 8'h00, FETCH);

    // JAM: DECODE is quiet, then HALT persists
    tick(); vec("jam_dec", 8'h02, 8'h00, IDLE);
    for (int i = 0; i < 22; i++) begin
      tick();
      vec($sformatf("halt_%0d", i), (i % 2 == 0) ? 8'hA9 : 8'h02, 8'h55,
          ec(0,0,0,0,0,0,2'b00,1,0));
    end
    reset = 1'b1;
    #1;
    check("halt_cleared", {3'b000, ctl}, {3'b000, IDLE});
    tick();
    reset = 1'b0;
    vec("rst3_cyc1", 8'hEA, 8'h00, IDLE);
    tick(); vec("rst3_cyc2", 8'hEA, 8'h00, IDLE);
    tick(); vec("rst3_fetch", 8'hEA, 8'h00, FETCH);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
